serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial two's-complement subtractor for the 8-bit datapath, computing `diff = a - b - borrow_in` one bit per clock, LSB first, through a single full-subtractor cell. It is the inverse-operation counterpart of the ripple full-adder chain. It trades latency for area in the ALU's SUB/CMP path, and uses a start/done handshake toward the control sequencer. Results and the borrow, zero and overflow flags are held stable until the next accepted start.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width in bits; must be at least 2.

Ports:
- `clk`, in, 1: single clock, rising-edge active.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: request; sampled only when in IDLE.
- `a`, in, WIDTH: minuend; sampled on the accepting edge only.
- `b`, in, WIDTH: subtrahend; sampled on the accepting edge only.
- `borrow_in`, in, 1: initial borrow; sampled on the accepting edge only.
- `busy`, out, 1: high while in SHIFT.
- `done`, out, 1: one-cycle pulse in the DONE state; results are valid from this cycle onward.
- `diff`, out, WIDTH: difference register.
- `borrow_out`, out, 1: final borrow. High means unsigned `a < b + borrow_in`.
- `zero`, out, 1: high when `diff == 0`.
- `overflow`, out, 1: signed overflow. Equals `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the latched operands.

## Operation

- FSM states:
  - IDLE: wait for `start`.
  - SHIFT: WIDTH bit-cycles, counter `cnt` running 0..WIDTH-1.
  - DONE: one cycle, then return to IDLE.
- IDLE with `start=1`:
  - Latch `a` and `b` into shift registers `ra` and `rb`.
  - Load the borrow flop `br` from `borrow_in`.
  - Latch `a[MSB]` and `b[MSB]` for the overflow calculation.
  - Clear `cnt` and go to SHIFT.
- `start` is ignored in SHIFT and DONE; there is no queueing.
- SHIFT, each cycle, with `x=ra[0]` and `y=rb[0]`:
  - `d = x ^ y ^ br`.
  - `br_next = (~x & y) | (~(x ^ y) & br)`.
  - Shift `ra` and `rb` right by one.
  - Shift `d` into the MSB of the result shift register; after WIDTH shifts, `diff[0]` holds bit 0.
  - Increment `cnt`.
- SHIFT to DONE on the edge where `cnt == WIDTH-1`. On that same edge:
  - `diff` receives its final value.
  - `borrow_out` receives `br_next`.
  - `zero` and `overflow` are computed from the final `diff`.
- DONE: `done=1`; go to IDLE on the next edge.
- Output stability during SHIFT:
  - `diff` is the internal shift register and is not stable while `busy=1`. Consumers read it only when `done=1` or later.
  - `borrow_out`, `zero` and `overflow` keep their previous values until the DONE transition.
- Reset (`rst_n` low, at any time, including mid-operation):
  - State goes to IDLE immediately.
  - `busy=0`, `done=0`, `diff=0`, `borrow_out=0`, `zero=0`, `overflow=0`, `cnt=0`.
  - Any in-flight operation is discarded.
- Arithmetic rules:
  - All arithmetic is modulo 2^WIDTH; wrap-around is reported via `borrow_out` (unsigned) and `overflow` (signed).
  - `borrow_in=1` with `a=b` yields all ones and `borrow_out=1`.

## Timing

- Accepting edge: the edge E at which IDLE and `start=1` are sampled.
- `busy` is high from after E through after E+WIDTH-1, i.e. WIDTH cycles.
- `done` is high for exactly one cycle, after E+WIDTH. Latency from start to done is WIDTH+1 edges (9 for WIDTH=8).
- Earliest next accept is at edge E+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- `start` held high continuously triggers back-to-back operations, each re-sampling the operands at its own accepting edge.
- Reset is asynchronous on assertion. Deassertion must be synchronous to `clk`; the synchronizer is outside this block. The first accept is possible on the first edge with `rst_n=1`.

## Test plan

- `a=8'h05`, `b=8'h03`, `borrow_in=0` -> after 9 edges `done=1`, `diff=8'h02`, `borrow_out=0`, `zero=0`, `overflow=0`. Check `busy` is high for exactly 8 cycles.
- `a=8'h03`, `b=8'h05` -> `diff=8'hFE`, `borrow_out=1`, `overflow=0`. Then `a=8'h80`, `b=8'h01` -> `diff=8'h7F`, `borrow_out=0`, `overflow=1`.
- `a=8'h42`, `b=8'h42`, `borrow_in=0` -> `diff=8'h00`, `zero=1`. Then the same operands with `borrow_in=1` -> `diff=8'hFF`, `borrow_out=1`, `zero=0`.
- Pulse `start` with `a=8'h10`, `b=8'h01`. In cycle 3, pulse `start` again with `a=8'hFF`, `b=8'hFF` -> the second request is ignored; result `diff=8'h0F`, with one `done` pulse only.
- Drop `rst_n` at cycle 4 of an operation -> all outputs read 0 immediately, with no `done` pulse. After release, `a=8'h7F`, `b=8'hFF` -> `diff=8'h80`, `borrow_out=1`, `overflow=1`.
- Random sweep: 1000 operand/borrow triples checked against the reference `{borrow_out, diff} = {1'b0, a} - {1'b0, b} - borrow_in`, with back-to-back `start` held high.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Start/done handshake; results and flags hold until the next accepted start.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  ra_q, ra_d;
  logic [WIDTH-1:0]  rb_q, rb_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic              br_q, br_d;
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              borrow_q, borrow_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;

  logic              x, y, d_bit, br_nxt;
  logic [WIDTH-1:0]  diff_fin;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    sr_d     = sr_q;
    br_d     = br_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    // Full-subtractor cell on the current LSBs
    x        = ra_q[0];
    y        = rb_q[0];
    d_bit    = x ^ y ^ br_q;
    br_nxt   = (~x & y) | (~(x ^ y) & br_q);
    diff_fin = {d_bit, sr_q[WIDTH-1:1]};

    case (state_q)
      StIdle: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          br_d    = borrow_in;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        sr_d  = diff_fin;
        br_d  = br_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Last bit: diff_fin is the complete result, so flags update together with it
          state_d  = StDone;
          cnt_d    = '0;
          borrow_d = br_nxt;
          zero_d   = (diff_fin == '0);
          ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      sr_q     <= '0;
      br_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      sr_q     <= sr_d;
      br_q     <= br_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy       = (state_q == StShift);
  assign done       = (state_q == StDone);
  assign diff       = sr_q;
  assign borrow_out = borrow_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;

endmodule
